// File: rtl/wb_periph_splitter_if.sv
// Bus bundle for wb_periph_splitter: upstream Wishbone port plus the shared downstream peripheral bus.
interface wb_periph_splitter_if #(
    parameter int N_SLAVES = 4
);
    logic                     wbs_cyc_i;
    logic                     wbs_stb_i;
    logic                     wbs_we_i;
    logic [3:0]               wbs_sel_i;
    logic [31:0]              wbs_adr_i;
    logic [31:0]              wbs_dat_i;
    logic                     wbs_ack_o;
    logic [31:0]              wbs_dat_o;
    logic                     s_cyc_o;
    logic [N_SLAVES-1:0]      s_stb_o;
    logic                     s_we_o;
    logic [3:0]               s_sel_o;
    logic [31:0]              s_adr_o;
    logic [31:0]              s_dat_o;
    logic [N_SLAVES-1:0]      s_ack_i;
    logic [32*N_SLAVES-1:0]   s_dat_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/wb_periph_splitter.sv
// Wishbone classic 1-to-N peripheral splitter with timeout, unmapped-address response and cyc-drop abort.
// Optional macro WB_SPLIT_ERR_EN adds wbs_err_o for unmapped/timed-out accesses.
module wb_periph_splitter #(
    parameter int          N_SLAVES    = 4,
    parameter int          SEL_LSB     = 16,
    parameter int          SEL_W       = 4,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] DEFAULT_DAT = 32'hDEADBEEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_periph_splitter_if.slave  bus,
`ifdef WB_SPLIT_ERR_EN
    output logic                 wbs_err_o,
`endif
    output logic                 timeout_irq_o
);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMAX     = '1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [SEL_W-1:0]    sel_idx;
    logic [SEL_W-1:0]    req_idx;
    logic                req_mapped;
    logic [N_SLAVES-1:0] req_onehot;
    logic                ack_hit;
    logic [31:0]         rd_dat;
    logic                timeout_hit;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TMAX) ? v : v + 1'b1;
    endfunction

    assign req_idx     = bus.wbs_adr_i[SEL_LSB +: SEL_W];
    assign req_mapped  = 32'(req_idx) < 32'(N_SLAVES);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer == TMO_LAST);

    always_comb begin
        req_onehot = '0;
        for (int k = 0; k < N_SLAVES; k++)
            if (req_idx == SEL_W'(k)) req_onehot[k] = 1'b1;
    end

    // Only the selected slave's ack and data are ever looked at.
    always_comb begin
        ack_hit = 1'b0;
        rd_dat  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_idx == SEL_W'(k)) begin
                ack_hit = bus.s_ack_i[k];
                rd_dat  = bus.s_dat_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= IDLE;
            timer         <= '0;
            sel_idx       <= '0;
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
            bus.s_cyc_o   <= 1'b0;
            bus.s_stb_o   <= '0;
            bus.s_we_o    <= 1'b0;
            bus.s_sel_o   <= '0;
            bus.s_adr_o   <= '0;
            bus.s_dat_o   <= '0;
            timeout_irq_o <= 1'b0;
`ifdef WB_SPLIT_ERR_EN
            wbs_err_o     <= 1'b0;
`endif
        end else begin
            bus.wbs_ack_o <= 1'b0;
            timeout_irq_o <= 1'b0;
`ifdef WB_SPLIT_ERR_EN
            wbs_err_o     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        bus.s_we_o  <= bus.wbs_we_i;
                        bus.s_sel_o <= bus.wbs_sel_i;
                        bus.s_adr_o <= bus.wbs_adr_i;
                        bus.s_dat_o <= bus.wbs_dat_i;
                        sel_idx     <= req_idx;
                        if (req_mapped) begin
                            bus.s_cyc_o <= 1'b1;
                            bus.s_stb_o <= req_onehot;
                            timer       <= '0;
                            state       <= BUSY;
                        end else begin
                            bus.wbs_dat_o <= DEFAULT_DAT;
`ifdef WB_SPLIT_ERR_EN
                            wbs_err_o     <= 1'b1;
`else
                            bus.wbs_ack_o <= 1'b1;
`endif
                            state         <= RESP;
                        end
                    end
                end
                // Abort beats ack, ack beats timeout.
                BUSY: begin
                    if (!bus.wbs_cyc_i) begin
                        bus.s_cyc_o <= 1'b0;
                        bus.s_stb_o <= '0;
                        state       <= IDLE;
                    end else if (ack_hit) begin
                        bus.s_cyc_o   <= 1'b0;
                        bus.s_stb_o   <= '0;
                        bus.wbs_dat_o <= rd_dat;
                        bus.wbs_ack_o <= 1'b1;
                        state         <= RESP;
                    end else if (timeout_hit) begin
                        bus.s_cyc_o   <= 1'b0;
                        bus.s_stb_o   <= '0;
                        bus.wbs_dat_o <= DEFAULT_DAT;
                        timeout_irq_o <= 1'b1;
`ifdef WB_SPLIT_ERR_EN
                        wbs_err_o     <= 1'b1;
`else
                        bus.wbs_ack_o <= 1'b1;
`endif
                        state         <= RESP;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_periph_splitter.sv
// Directed bench for wb_periph_splitter (N_SLAVES=4, TIMEOUT_CYC=8); honours WB_SPLIT_ERR_EN if defined.
module tb_wb_periph_splitter;
    logic clk;
    logic rst_n;
    logic irq;
`ifdef WB_SPLIT_ERR_EN
    logic err;
`endif
    int total = 0;
    int bad   = 0;

    wb_periph_splitter_if #(.N_SLAVES(4)) bus ();

    wb_periph_splitter #(
        .N_SLAVES(4), .SEL_LSB(16), .SEL_W(4), .TIMEOUT_CYC(8), .DEFAULT_DAT(32'hDEADBEEF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .bus(bus),
`ifdef WB_SPLIT_ERR_EN
        .wbs_err_o(err),
`endif
        .timeout_irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic idle_bus();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.s_ack_i   = '0;
    endtask

    // Unmapped/timeout completion: ack in the default build, err with the option.
    task automatic chk_fault_resp(input string tag);
`ifdef WB_SPLIT_ERR_EN
        chk({tag, "_err"}, 32'(err), 32'h1);
        chk({tag, "_ack"}, 32'(bus.wbs_ack_o), 32'h0);
`else
        chk({tag, "_ack"}, 32'(bus.wbs_ack_o), 32'h1);
`endif
        chk({tag, "_dat"}, bus.wbs_dat_o, 32'hDEADBEEF);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_bus();
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.s_dat_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("rst_dat", bus.wbs_dat_o, 32'h0);
        chk("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst_stb", 32'(bus.s_stb_o), 32'h0);
        chk("rst_adr", bus.s_adr_o, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        tick();

        // Read slave 1, acked two cycles after the strobe; a stray ack from slave 0 must be ignored.
        req(1'b0, 4'hF, 32'h0001_0004, 32'h0);
        tick();
        chk("rd_stb", 32'(bus.s_stb_o), 32'h2);
        chk("rd_cyc", 32'(bus.s_cyc_o), 32'h1);
        chk("rd_adr", bus.s_adr_o, 32'h0001_0004);
        bus.s_ack_i = 4'b0001;
        bus.s_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_0BAD};
        tick();
        chk("rd_stray_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("rd_stb_hold", 32'(bus.s_stb_o), 32'h2);
        bus.s_ack_i = 4'b0010;
        tick();
        chk("rd_ack", 32'(bus.wbs_ack_o), 32'h1);
        chk("rd_dat", bus.wbs_dat_o, 32'h1234_5678);
        chk("rd_stb_clr", 32'(bus.s_stb_o), 32'h0);
        chk("rd_cyc_clr", 32'(bus.s_cyc_o), 32'h0);
        idle_bus();
        tick();
        chk("rd_ack_once", 32'(bus.wbs_ack_o), 32'h0);

        // Zero-wait write to slave 2, then an unmapped read issued back-to-back.
        req(1'b1, 4'b0011, 32'h0002_0000, 32'hA5A5_0F0F);
        tick();
        chk("wr_stb", 32'(bus.s_stb_o), 32'h4);
        chk("wr_we", 32'(bus.s_we_o), 32'h1);
        chk("wr_sel", 32'(bus.s_sel_o), 32'h3);
        chk("wr_dat", bus.s_dat_o, 32'hA5A5_0F0F);
        bus.s_ack_i = 4'b0100;
        tick();
        chk("wr_ack", 32'(bus.wbs_ack_o), 32'h1);
        chk("wr_stb_clr", 32'(bus.s_stb_o), 32'h0);
        bus.s_ack_i = '0;
        req(1'b0, 4'hF, 32'h0009_0000, 32'h0);
        tick();
        chk("b2b_idle_ack", 32'(bus.wbs_ack_o), 32'h0);
        tick();
        chk_fault_resp("unmap");
        chk("unmap_stb", 32'(bus.s_stb_o), 32'h0);
        chk("unmap_cyc", 32'(bus.s_cyc_o), 32'h0);
        idle_bus();
        tick();

        // Slave 3 never acks: strobe held for 8 cycles, then timeout response.
        req(1'b0, 4'hF, 32'h0003_0000, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("tmo_stb", 32'(bus.s_stb_o), 32'h8);
            chk("tmo_irq_lo", 32'(irq), 32'h0);
        end
        tick();
        chk("tmo_stb_clr", 32'(bus.s_stb_o), 32'h0);
        chk("tmo_irq", 32'(irq), 32'h1);
        chk_fault_resp("tmo");
        idle_bus();
        tick();
        chk("tmo_irq_pulse", 32'(irq), 32'h0);

        // cyc dropped in the second BUSY cycle together with a slave ack.
        req(1'b0, 4'hF, 32'h0001_0000, 32'h0);
        tick();
        tick();
        idle_bus();
        bus.s_ack_i = 4'b0010;
        tick();
        chk("abort_stb", 32'(bus.s_stb_o), 32'h0);
        chk("abort_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("abort_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("abort_irq", 32'(irq), 32'h0);
        bus.s_ack_i = '0;
        tick();
        chk("abort_ack2", 32'(bus.wbs_ack_o), 32'h0);
        req(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        bus.s_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h00C0_FFEE};
        tick();
        chk("post_abort_stb", 32'(bus.s_stb_o), 32'h1);
        bus.s_ack_i = 4'b0001;
        tick();
        chk("post_abort_ack", 32'(bus.wbs_ack_o), 32'h1);
        chk("post_abort_dat", bus.wbs_dat_o, 32'h00C0_FFEE);
        idle_bus();
        tick();

        // Asynchronous reset while BUSY, then a normal read to slave 2.
        req(1'b0, 4'hF, 32'h0003_0008, 32'h0);
        tick();
        chk("pre_rst_stb", 32'(bus.s_stb_o), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stb", 32'(bus.s_stb_o), 32'h0);
        chk("arst_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("arst_adr", bus.s_adr_o, 32'h0);
        chk("arst_dat", bus.wbs_dat_o, 32'h0);
        idle_bus();
        tick();
        rst_n = 1'b1;
        tick();
        req(1'b0, 4'hF, 32'h0002_0004, 32'h0);
        bus.s_dat_i = {32'h3333_3333, 32'h2222_0000, 32'h1111_1111, 32'h0000_0000};
        tick();
        chk("post_rst_stb", 32'(bus.s_stb_o), 32'h4);
        chk("post_rst_adr", bus.s_adr_o, 32'h0002_0004);
        bus.s_ack_i = 4'b0100;
        tick();
        chk("post_rst_ack", 32'(bus.wbs_ack_o), 32'h1);
        chk("post_rst_dat", bus.wbs_dat_o, 32'h2222_0000);
        idle_bus();
        tick();
        chk("final_ack", 32'(bus.wbs_ack_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_periph_splitter.md
Name: wb_periph_splitter

Overview:
Parametrised Wishbone classic slave-side splitter: one upstream Wishbone port fanned out to N_SLAVES peripheral ports, selected by an address field. Registers each request, drives exactly one downstream strobe and returns a registered ack. Adds per-transaction timeout, unmapped-address handling and abort on cyc drop. Sits between the user-project Wishbone port and the timer/UART/SRAM-class peripherals.

Parameters:
N_SLAVES, 4, number of downstream ports (1..16)
SEL_LSB, 16, lowest address bit of the slave-select field
SEL_W, 4, width of the slave-select field; index >= N_SLAVES is unmapped
TIMEOUT_CYC, 255, max BUSY cycles before forced response; 0 disables timeout
DEFAULT_DAT, 32'hDEADBEEF, read data returned on unmapped or timed-out access

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous, active-low
wbs_cyc_i  in  1  upstream cycle
wbs_stb_i  in  1  upstream strobe
wbs_we_i  in  1  upstream write enable
wbs_sel_i  in  4  upstream byte selects
wbs_adr_i  in  32  upstream address
wbs_dat_i  in  32  upstream write data
wbs_ack_o  out  1  upstream ack, registered
wbs_dat_o  out  32  upstream read data, registered
s_cyc_o  out  1  shared downstream cycle
s_stb_o  out  N_SLAVES  one-hot downstream strobes
s_we_o  out  1  latched write enable
s_sel_o  out  4  latched byte selects
s_adr_o  out  32  latched address
s_dat_o  out  32  latched write data
s_ack_i  in  N_SLAVES  downstream acks
s_dat_i  in  32*N_SLAVES  downstream read data, slave k at bits [32k+31:32k]
timeout_irq_o  out  1  one-cycle pulse on each timeout

Behaviour:
- Reset: state IDLE; wbs_ack_o=0, wbs_dat_o=0, s_cyc_o=0, s_stb_o=0, s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0, timeout_irq_o=0, timer=0.
- States: IDLE, BUSY, RESP.
- IDLE: on cyc&stb, latch adr/dat/we/sel and idx=adr[SEL_LSB+SEL_W-1:SEL_LSB]. Mapped -> BUSY, next cycle s_cyc_o=1, s_stb_o[idx]=1, timer=0. Unmapped -> RESP with wbs_dat_o=DEFAULT_DAT; no downstream strobe.
- BUSY: only s_ack_i[idx] is sampled; other acks ignored. On s_ack_i[idx]: capture s_dat_i slice idx into wbs_dat_o, clear s_cyc_o/s_stb_o next edge, -> RESP. Else timer++; when TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1 without ack: clear strobes, wbs_dat_o=DEFAULT_DAT, pulse timeout_irq_o, -> RESP.
- RESP: wbs_ack_o=1 for exactly one cycle, -> IDLE. Writes also return ack; wbs_dat_o on writes holds captured slave data (don't-care to master).
- Latency: slave ack in cycle k -> wbs_ack_o in cycle k+1. Zero-wait slave: request at cycle 0, s_stb_o at 1, wbs_ack_o at 2. Unmapped: wbs_ack_o at cycle 1.
- Abort: wbs_cyc_i low while BUSY -> clear s_cyc_o/s_stb_o next edge, -> IDLE, no ack, no irq. Slave ack in same cycle as abort is discarded.
- Ack and timeout in same cycle: ack wins, slave data returned, no irq.
- Back-to-back: new request accepted in the IDLE cycle immediately after RESP; max one transaction per 3 cycles.
- s_stb_o is one-hot or zero at all times; asserted only while s_cyc_o=1.
- Timer width clog2(TIMEOUT_CYC+1), saturates; never wraps.
- Async reset mid-transaction: all outputs to reset values immediately, pending transaction dropped.

Optional Feature:
WB_SPLIT_ERR_EN: defined -> adds port wbs_err_o (out, 1, reset 0); unmapped and timed-out accesses drive wbs_err_o=1 for the RESP cycle instead of wbs_ack_o, wbs_dat_o still DEFAULT_DAT. Undefined -> no port; those cases complete with wbs_ack_o as above.

Test Plan:
- Read adr 0x0001_0004, slave 1 acks 2 cycles after strobe with 0x1234_5678 -> s_stb_o=4'b0010, s_adr_o=0x0001_0004, wbs_dat_o=0x1234_5678, one-cycle wbs_ack_o.
- Write adr 0x0002_0000 dat 0xA5A5_0F0F sel 4'b0011 -> s_dat_o/s_sel_o/s_we_o latched, s_stb_o=4'b0100, ack one cycle after slave ack.
- Read adr 0x0009_0000 (N_SLAVES=4) -> no s_stb_o, wbs_ack_o at cycle 1, wbs_dat_o=0xDEADBEEF; with WB_SPLIT_ERR_EN, wbs_err_o=1 and wbs_ack_o=0.
- TIMEOUT_CYC=8, slave 3 never acks -> s_stb_o[3] high 8 cycles, timeout_irq_o pulse, wbs_ack_o with 0xDEADBEEF.
- Drop wbs_cyc_i in 2nd BUSY cycle with slave ack same cycle -> strobes cleared, no wbs_ack_o, next request to slave 0 serviced normally.
- Assert wb_rst_ni=0 while BUSY -> all outputs 0 asynchronously; after release, read to slave 2 completes normally.
